// File: rtl/tmr0_prescaler_if.sv
// Purpose : signal bundle between the core (OPTION/W/strobes) and Timer0.
// Latency : n/a (wires only).
// Backpressure: none; every strobe is a single-cycle pulse that is always accepted.
//
// Ports (master = core side, slave = timer side):
//   OPTION, OPTION_wr, W, TMR0_wr, CLRWDT, T0CKI, WDT_tick_in  -> timer
//   TMR0, TMR0_ovf, WDT_tick                                    <- timer
//   T0IF_clr -> timer, T0IF <- timer      (only with TMR0_OVF_FLAG_EN)
interface tmr0_prescaler_if;
  logic [7:0] OPTION;
  logic       OPTION_wr;
  logic [7:0] W;
  logic       TMR0_wr;
  logic       CLRWDT;
  logic       T0CKI;
  logic       WDT_tick_in;
  logic [7:0] TMR0;
  logic       TMR0_ovf;
  logic       WDT_tick;
`ifdef TMR0_OVF_FLAG_EN
  logic       T0IF_clr;
  logic       T0IF;
`endif

  modport master (
    output OPTION, OPTION_wr, W, TMR0_wr, CLRWDT, T0CKI, WDT_tick_in,
`ifdef TMR0_OVF_FLAG_EN
    output T0IF_clr,
    input  T0IF,
`endif
    input  TMR0, TMR0_ovf, WDT_tick
  );

  modport slave (
    input  OPTION, OPTION_wr, W, TMR0_wr, CLRWDT, T0CKI, WDT_tick_in,
`ifdef TMR0_OVF_FLAG_EN
    input  T0IF_clr,
    output T0IF,
`endif
    output TMR0, TMR0_ovf, WDT_tick
  );
endinterface

// File: rtl/tmr0_prescaler.sv
// Purpose : Timer0 with shared 8-bit prescaler (TMR0 or WDT), decoded from OPTION.
// Latency : internal tick -> TMR0 next edge; T0CKI edge -> TMR0 after SYNC_STAGES+1 edges.
// Backpressure: none; writes and strobes always accepted, TMR0 writes inhibit counting.
//
// Ports: clk, rst (async, active-high); bus (tmr0_prescaler_if.slave).
// Optional feature macro: TMR0_OVF_FLAG_EN adds the sticky T0IF flag with T0IF_clr.
module tmr0_prescaler #(
  parameter int SYNC_STAGES = 2,  // T0CKI synchronizer depth, must be >= 2
  parameter int INHIBIT_CYC = 2   // increments dropped after a TMR0 write
) (
  input  logic clk,
  input  logic rst,
  tmr0_prescaler_if.slave bus
);

  localparam int CW = (INHIBIT_CYC < 1) ? 1 : $clog2(INHIBIT_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [7:0]             pre_q, pre_d;
  logic [7:0]             tmr_q, tmr_d;
  logic [CW-1:0]          inh_q, inh_d;
  logic                   ovf_q, ovf_d;
  logic                   wdt_q, wdt_d;

  logic       t0cs, t0se, psa;
  logic [2:0] ps;
  logic       sync_last, ext_ev, src_ev, tmr_tick;
  logic [7:0] mask_tmr, mask_wdt;
  logic       pre_full_tmr, pre_full_wdt, pre_inc, pre_clr;
  logic       unused_option;

  assign t0cs = bus.OPTION[5];
  assign t0se = bus.OPTION[4];
  assign psa  = bus.OPTION[3];
  assign ps   = bus.OPTION[2:0];
  assign unused_option = ^bus.OPTION[7:6];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.T0CKI};
    sync_last = sync_q[SYNC_STAGES-1];
    edge_d    = sync_last;
    // edge_q holds the previous synchronized level; compare against it for the edge
    ext_ev    = t0se ? (~sync_last & edge_q) : (sync_last & ~edge_q);
    src_ev    = t0cs ? ext_ev : 1'b1;

    // Low PS+1 bits for TMR0 (1:2..1:256), low PS bits for WDT (1:1..1:128)
    mask_tmr     = 8'hFF >> (3'd7 - ps);
    mask_wdt     = 8'h7F >> (3'd7 - ps);
    pre_full_tmr = &(pre_q | ~mask_tmr);
    pre_full_wdt = &(pre_q | ~mask_wdt);

    tmr_tick = psa ? src_ev : (src_ev & pre_full_tmr);
    pre_inc  = psa ? bus.WDT_tick_in : src_ev;
    pre_clr  = bus.OPTION_wr | (bus.TMR0_wr & ~psa) | (bus.CLRWDT & psa);

    pre_d = pre_q;
    if (pre_clr)      pre_d = 8'h00;
    else if (pre_inc) pre_d = pre_q + 8'd1;

    // With the prescaler on TMR0 the watchdog runs unprescaled
    wdt_d = bus.WDT_tick_in & (~psa | pre_full_wdt);

    tmr_d = tmr_q;
    inh_d = inh_q;
    ovf_d = 1'b0;
    if (bus.TMR0_wr) begin
      tmr_d = bus.W;
      inh_d = CW'(INHIBIT_CYC);
    end else if (inh_q != '0) begin
      inh_d = inh_q - 1'b1;
    end else if (tmr_tick) begin
      tmr_d = tmr_q + 8'd1;
      ovf_d = (tmr_q == 8'hFF);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      pre_q  <= 8'h00;
      tmr_q  <= 8'h00;
      inh_q  <= '0;
      ovf_q  <= 1'b0;
      wdt_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
      pre_q  <= pre_d;
      tmr_q  <= tmr_d;
      inh_q  <= inh_d;
      ovf_q  <= ovf_d;
      wdt_q  <= wdt_d;
    end
  end

  assign bus.TMR0     = tmr_q;
  assign bus.TMR0_ovf = ovf_q;
  assign bus.WDT_tick = wdt_q;

`ifdef TMR0_OVF_FLAG_EN
  logic t0if_q, t0if_d;

  // Set beats a same-cycle clear so an overflow is never lost
  always_comb begin
    t0if_d = t0if_q;
    if (ovf_q)             t0if_d = 1'b1;
    else if (bus.T0IF_clr) t0if_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) t0if_q <= 1'b0;
    else     t0if_q <= t0if_d;
  end

  assign bus.T0IF = t0if_q;
`endif

endmodule

// File: tb/tb_tmr0_prescaler.sv
// Purpose : directed self-checking bench for tmr0_prescaler.
// Latency : n/a.
// Backpressure: n/a.
module tb_tmr0_prescaler;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cnt;
  int   first_idx;

  tmr0_prescaler_if bus();

  tmr0_prescaler #(.SYNC_STAGES(2), .INHIBIT_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.OPTION      = 8'h00;
    bus.OPTION_wr   = 1'b0;
    bus.W           = 8'h00;
    bus.TMR0_wr     = 1'b0;
    bus.CLRWDT      = 1'b0;
    bus.T0CKI       = 1'b0;
    bus.WDT_tick_in = 1'b0;
`ifdef TMR0_OVF_FLAG_EN
    bus.T0IF_clr    = 1'b0;
`endif

    // Reset state
    #2;
    chk("rst_tmr0", 32'(bus.TMR0), 32'h00);
    chk("rst_ovf",  32'(bus.TMR0_ovf), 32'h0);
    chk("rst_wdt",  32'(bus.WDT_tick), 32'h0);
    chk("rst_pre",  32'(dut.pre_q), 32'h00);
    step(2);
    chk("rst_hold", 32'(bus.TMR0), 32'h00);
    rst = 1'b0;

    // Internal clock, 1:2: pre[0] toggles each cycle, TMR0 = k/2
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("t1_pre0", 32'(dut.pre_q[0]), 32'(k & 1));
      chk("t1_tmr0", 32'(bus.TMR0), 32'(k / 2));
    end
    chk("t1_final", 32'(bus.TMR0), 32'h05);

    // 1:4 with combined OPTION/TMR0 write: prescaler cleared, write wins
    bus.OPTION = 8'h01; bus.OPTION_wr = 1'b1; bus.TMR0_wr = 1'b1; bus.W = 8'h10;
    step(1);
    bus.OPTION_wr = 1'b0; bus.TMR0_wr = 1'b0;
    chk("ps4_wr",  32'(bus.TMR0), 32'h10);
    chk("ps4_pre", 32'(dut.pre_q), 32'h00);
    step(3);
    chk("ps4_e3", 32'(bus.TMR0), 32'h10);
    step(1);
    chk("ps4_e4", 32'(bus.TMR0), 32'h11);
    step(4);
    chk("ps4_e8", 32'(bus.TMR0), 32'h12);

    // PSA=1, write 0xFE, inhibit then overflow
    bus.OPTION = 8'h08; bus.TMR0_wr = 1'b1; bus.W = 8'hFE;
    step(1);
    bus.TMR0_wr = 1'b0;
    chk("t2_wr", 32'(bus.TMR0), 32'hFE);
    step(1);
    chk("t2_inh1", 32'(bus.TMR0), 32'hFE);
    step(1);
    chk("t2_inh2", 32'(bus.TMR0), 32'hFE);
    step(1);
    chk("t2_ff",     32'(bus.TMR0), 32'hFF);
    chk("t2_ff_ovf", 32'(bus.TMR0_ovf), 32'h0);
    step(1);
    chk("t2_00",     32'(bus.TMR0), 32'h00);
    chk("t2_00_ovf", 32'(bus.TMR0_ovf), 32'h1);
    step(1);
    chk("t2_01",     32'(bus.TMR0), 32'h01);
    chk("t2_01_ovf", 32'(bus.TMR0_ovf), 32'h0);

    // Writing 0x00 is not an overflow
    bus.TMR0_wr = 1'b1; bus.W = 8'h00;
    step(1);
    bus.TMR0_wr = 1'b0;
    chk("wr0_tmr0", 32'(bus.TMR0), 32'h00);
    chk("wr0_ovf",  32'(bus.TMR0_ovf), 32'h0);

    // External falling edge, 1:1: increments land 3 clk after the falling edge
    bus.OPTION = 8'h38; bus.TMR0_wr = 1'b1; bus.W = 8'h00;
    step(1);
    bus.TMR0_wr = 1'b0;
    step(3);
    chk("t3_start", 32'(bus.TMR0), 32'h00);
    for (int p = 0; p < 4; p++) begin
      bus.T0CKI = 1'b1;
      step(4);
      chk("t3_rise", 32'(bus.TMR0), 32'(p));
      bus.T0CKI = 1'b0;
      step(2);
      chk("t3_fall_e2", 32'(bus.TMR0), 32'(p));
      step(1);
      chk("t3_fall_e3", 32'(bus.TMR0), 32'(p + 1));
      step(2);
    end
    chk("t3_final", 32'(bus.TMR0), 32'h04);

    // WDT prescale 1:128: 256 pulses -> 2 ticks, first on pulse 128
    bus.OPTION = 8'h0F; bus.OPTION_wr = 1'b1;
    step(1);
    bus.OPTION_wr = 1'b0;
    cnt = 0; first_idx = 0;
    for (int i = 1; i <= 256; i++) begin
      bus.WDT_tick_in = 1'b1;
      step(1);
      bus.WDT_tick_in = 1'b0;
      if (bus.WDT_tick) begin
        cnt++;
        if (first_idx == 0) first_idx = i;
      end
      step(1);
      if (bus.WDT_tick) cnt = cnt + 100;  // tick must never linger past one cycle
    end
    chk("t4_ticks", 32'(cnt), 32'd2);
    chk("t4_first", 32'(first_idx), 32'd128);

    // CLRWDT on pulse 100 restarts the count: one tick, on pulse 228
    bus.OPTION_wr = 1'b1;
    step(1);
    bus.OPTION_wr = 1'b0;
    cnt = 0; first_idx = 0;
    for (int i = 1; i <= 256; i++) begin
      bus.WDT_tick_in = 1'b1;
      bus.CLRWDT = (i == 100);
      step(1);
      bus.WDT_tick_in = 1'b0;
      bus.CLRWDT = 1'b0;
      if (bus.WDT_tick) begin
        cnt++;
        if (first_idx == 0) first_idx = i;
      end
      step(1);
    end
    chk("t4c_ticks", 32'(cnt), 32'd1);
    chk("t4c_first", 32'(first_idx), 32'd228);

    // Async reset mid-run takes effect before the next edge
    bus.OPTION = 8'h08; bus.TMR0_wr = 1'b1; bus.W = 8'h37;
    step(1);
    bus.TMR0_wr = 1'b0;
    chk("t5_pre",     32'(bus.TMR0), 32'h37);
    chk("t5_pre_nz",  32'(dut.pre_q != 8'h00), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("t5_tmr0", 32'(bus.TMR0), 32'h00);
    chk("t5_pres", 32'(dut.pre_q), 32'h00);
    step(1);
    rst = 1'b0;

`ifdef TMR0_OVF_FLAG_EN
    // Sticky overflow flag
    chk("t6_rst", 32'(bus.T0IF), 32'h0);
    bus.TMR0_wr = 1'b1; bus.W = 8'hFF;
    step(1);
    bus.TMR0_wr = 1'b0;
    step(3);
    chk("t6_ovf", 32'(bus.TMR0_ovf), 32'h1);
    step(1);
    chk("t6_set", 32'(bus.T0IF), 32'h1);
    step(5);
    chk("t6_hold", 32'(bus.T0IF), 32'h1);
    bus.T0IF_clr = 1'b1;
    step(1);
    bus.T0IF_clr = 1'b0;
    chk("t6_clr", 32'(bus.T0IF), 32'h0);
    // Clear asserted during the overflow cycle: set wins
    bus.TMR0_wr = 1'b1; bus.W = 8'hFF;
    step(1);
    bus.TMR0_wr = 1'b0;
    step(3);
    chk("t6_ovf2", 32'(bus.TMR0_ovf), 32'h1);
    bus.T0IF_clr = 1'b1;
    step(1);
    bus.T0IF_clr = 1'b0;
    chk("t6_setwins", 32'(bus.T0IF), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
